crc_check: RTL and testbench
============================

CRC_CHECK -- requirements
Module: crc_check

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter ERR_THRESH, default 3, consecutive bad words that raise ALARM.
REQ-003 SHALL have parameter CLR_THRESH, default 8, consecutive good words that clear ALARM.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port D_IN  input  36  received codeword: [35:4] data, [3:0] CRC.
REQ-007 SHALL have port VALID_IN  input  1  D_IN valid this cycle.
REQ-008 SHALL have port READY_IN  output  1  block can accept D_IN.
REQ-009 SHALL have port D_OUT  output  32  data field of the FIFO head word.
REQ-010 SHALL have port ERR_OUT  output  1  head word failed the CRC check.
REQ-011 SHALL have port VALID_OUT  output  1  FIFO head valid.
REQ-012 SHALL have port READY_OUT  input  1  consumer accepts the head word.
REQ-013 SHALL have port GOOD_CNT  output  16  count of accepted good words.
REQ-014 SHALL have port BAD_CNT  output  16  count of accepted bad words.
REQ-015 SHALL have port ALARM  output  1  link-error alarm state.

Function
REQ-016 SHALL check against generator x^4+x+1 (5'b10011); codes are MSB-first long division of all 36 bits, and a word is good iff the remainder is 4'h0.
REQ-017 SHALL accept a word on any posedge with VALID_IN=1 and READY_IN=1; there is no other accept condition.
REQ-018 SHALL compute the check combinationally on D_IN; at accept, push {D_IN[35:4], bad} into the FIFO.
REQ-019 SHALL drive READY_IN=1 iff FIFO occupancy < FIFO_DEPTH (registered occupancy, no combinational path from READY_OUT).
REQ-020 SHALL drive VALID_OUT=1 iff occupancy > 0; D_OUT/ERR_OUT show the head word, and the head is popped on a posedge with VALID_OUT=1 and READY_OUT=1.
REQ-021 SHALL have latency 1: a word accepted into an empty FIFO appears with VALID_OUT=1 the next cycle.
REQ-022 SHALL keep occupancy unchanged and order preserved on a simultaneous push and pop; a push is impossible when full (READY_IN=0) even if a pop occurs that cycle.
REQ-023 SHALL wrap read/write pointers modulo FIFO_DEPTH; head data SHALL stay stable while VALID_OUT=1 and READY_OUT=0.
REQ-024 SHALL increment GOOD_CNT or BAD_CNT by 1 per accepted word, saturating at 16'hFFFF (no wrap).
REQ-025 SHALL implement an FSM with states NORMAL and ALARM; the run counters are cleared on every state transition.
REQ-026 In NORMAL: run counter counts consecutive accepted bad words and clears on a good word; the ERR_THRESH-th consecutive bad accept -> ALARM.
REQ-027 In ALARM: run counter counts consecutive accepted good words and clears on a bad word; the CLR_THRESH-th consecutive good accept -> NORMAL.
REQ-028 SHALL leave counters and FSM unchanged in cycles without an accept; the FSM is independent of READY_OUT.
REQ-029 SHALL register ALARM: ALARM=1 in the cycle after the transition-causing accept.

Reset
REQ-030 SHALL, while RST=1 at a posedge, set FIFO empty, pointers 0, VALID_OUT=0, READY_IN=1, D_OUT=0, ERR_OUT=0, GOOD_CNT=0, BAD_CNT=0, ALARM=0, FSM=NORMAL, run counters 0.
REQ-031 SHALL give RST priority over simultaneous accept or pop; words in flight are discarded, with nothing accepted or popped in the reset cycle.
REQ-032 SHALL resume normal operation the first posedge after RST deasserts; RST held 2 cycles at simulation start.

Verification
REQ-033 Good/bad: D_IN=36'h000000013, then 36'h800000006, then 36'h000000010, READY_OUT=1 -> ERR_OUT 0,0,1 with D_OUT 32'h00000001, 32'h80000000, 32'h00000001; GOOD_CNT=2, BAD_CNT=1.
REQ-034 Backpressure: READY_OUT=0, VALID_IN=1 for 6 cycles -> READY_IN=0 after 4 accepts; on READY_OUT=1, 4 words drain in order, then accepting resumes.
REQ-035 Alarm: 3 consecutive bad words -> ALARM=1 the next cycle; a good/bad interleave stays in ALARM; 8 consecutive good words -> ALARM=0 the next cycle.
REQ-036 Simultaneous push/pop at occupancy 2 -> occupancy stays 2, output order intact.
REQ-037 Mid-operation reset: FIFO at 3, ALARM=1, BAD_CNT=5, assert RST 1 cycle -> all REQ-030 values next cycle, with no stale word emitted.
REQ-038 Saturation: force BAD_CNT to 16'hFFFE, feed 3 bad words -> BAD_CNT holds at 16'hFFFF.

Source files
------------

// File: rtl/crc_check.sv
// CRC-4 (x^4+x+1) receive checker: tags each accepted codeword good/bad, queues it
// in a small FIFO, keeps saturating good/bad counts and a hysteretic link-error alarm.
module crc_check #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_THRESH = 3,
  parameter int CLR_THRESH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [35:0] D_IN,
  input  logic        VALID_IN,
  output logic        READY_IN,
  output logic [31:0] D_OUT,
  output logic        ERR_OUT,
  output logic        VALID_OUT,
  input  logic        READY_OUT,
  output logic [15:0] GOOD_CNT,
  output logic [15:0] BAD_CNT,
  output logic        ALARM
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int RUN_MX = (ERR_THRESH > CLR_THRESH) ? ERR_THRESH : CLR_THRESH;
  localparam int RW     = $clog2(RUN_MX + 1);

  typedef enum logic {ST_NORMAL, ST_ALARM} state_t;

  // Long division unrolled one bit per stage, MSB first; stage gi consumes D_IN[35-gi].
  logic [36:0][3:0] rem_chain;
  assign rem_chain[0] = 4'h0;

  genvar gi;
  generate
    for (gi = 0; gi < 36; gi++) begin : g_div
      logic [4:0] shift_w;
      assign shift_w = {rem_chain[gi], D_IN[35-gi]};
      assign rem_chain[gi+1] = shift_w[4] ? (shift_w[3:0] ^ 4'b0011) : shift_w[3:0];
    end
  endgenerate

  logic word_bad;
  assign word_bad = |rem_chain[36];

  // FIFO storage: {data, bad}
  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push;
  logic          pop;
  logic [32:0]   head;

  assign READY_IN  = (count_reg < CW'(FIFO_DEPTH));
  assign VALID_OUT = (count_reg != '0);
  assign push      = VALID_IN && READY_IN;
  assign pop       = VALID_OUT && READY_OUT;
  assign head      = mem[rd_ptr_reg];
  assign D_OUT     = VALID_OUT ? head[32:1] : 32'h0;
  assign ERR_OUT   = VALID_OUT && head[0];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= {D_IN[35:4], word_bad};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  logic [15:0] good_cnt_reg;
  logic [15:0] bad_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
    end else if (push) begin
      if (word_bad) begin
        if (bad_cnt_reg != 16'hFFFF) bad_cnt_reg <= bad_cnt_reg + 16'd1;
      end else begin
        if (good_cnt_reg != 16'hFFFF) good_cnt_reg <= good_cnt_reg + 16'd1;
      end
    end
  end

  assign GOOD_CNT = good_cnt_reg;
  assign BAD_CNT  = bad_cnt_reg;

  state_t        state_reg;
  state_t        state_next;
  logic [RW-1:0] run_reg;
  logic [RW-1:0] run_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_NORMAL;
      run_reg   <= '0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
    end
  end

  // The run counter tracks bad words while NORMAL and good words while in ALARM.
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    if (push) begin
      case (state_reg)
        ST_NORMAL: begin
          if (!word_bad) begin
            run_next = '0;
          end else if (run_reg >= RW'(ERR_THRESH - 1)) begin
            state_next = ST_ALARM;
            run_next   = '0;
          end else begin
            run_next = run_reg + RW'(1);
          end
        end
        default: begin
          if (word_bad) begin
            run_next = '0;
          end else if (run_reg >= RW'(CLR_THRESH - 1)) begin
            state_next = ST_NORMAL;
            run_next   = '0;
          end else begin
            run_next = run_reg + RW'(1);
          end
        end
      endcase
    end
  end

  assign ALARM = (state_reg == ST_ALARM);

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check: a queue/arithmetic model checked on every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_crc_check;
  localparam int DEPTH = 4;
  localparam int ETH   = 3;
  localparam int CTH   = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic [35:0] D_IN;
  logic        VALID_IN;
  logic        READY_IN;
  logic [31:0] D_OUT;
  logic        ERR_OUT;
  logic        VALID_OUT;
  logic        READY_OUT;
  logic [15:0] GOOD_CNT;
  logic [15:0] BAD_CNT;
  logic        ALARM;

  always #5 CLK = ~CLK;

  crc_check #(.FIFO_DEPTH(DEPTH), .ERR_THRESH(ETH), .CLR_THRESH(CTH)) dut (
    .CLK(CLK), .RST(RST), .D_IN(D_IN), .VALID_IN(VALID_IN), .READY_IN(READY_IN),
    .D_OUT(D_OUT), .ERR_OUT(ERR_OUT), .VALID_OUT(VALID_OUT), .READY_OUT(READY_OUT),
    .GOOD_CNT(GOOD_CNT), .BAD_CNT(BAD_CNT), .ALARM(ALARM)
  );

  int          errors = 0;
  int          checks = 0;
  logic [32:0] m_q[$];
  logic [15:0] m_good = 16'h0;
  logic [15:0] m_bad  = 16'h0;
  bit          m_alarm = 1'b0;
  int          m_run = 0;

  // Remainder as a sum of x^i mod g over the set bits of the word.
  function automatic logic [3:0] model_rem(input logic [35:0] w);
    logic [4:0] p;
    logic [3:0] r;
    p = 5'd1;
    r = 4'h0;
    for (int i = 0; i < 36; i++) begin
      if (w[i]) r = r ^ p[3:0];
      p = p << 1;
      if (p[4]) p = p ^ 5'b10011;
    end
    return r;
  endfunction

  function automatic logic [35:0] mk_good(input logic [31:0] d);
    return {d, model_rem({d, 4'h0})};
  endfunction

  function automatic logic [35:0] mk_bad(input logic [31:0] d);
    return {d, model_rem({d, 4'h0}) ^ 4'h1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit acc;
    bit bad;
    if (RST) begin
      m_q.delete();
      m_good  = 16'h0;
      m_bad   = 16'h0;
      m_alarm = 1'b0;
      m_run   = 0;
    end else begin
      acc = VALID_IN && (m_q.size() < DEPTH);
      if (m_q.size() > 0 && READY_OUT) begin
        $display("xfer out data=%h err=%0d", m_q[0][32:1], m_q[0][0]);
        void'(m_q.pop_front());
      end
      if (acc) begin
        bad = (model_rem(D_IN) != 4'h0);
        $display("xfer in  word=%h bad=%0d", D_IN, bad);
        m_q.push_back({D_IN[35:4], bad});
        if (bad && m_bad != 16'hFFFF) m_bad++;
        if (!bad && m_good != 16'hFFFF) m_good++;
        if (bad != m_alarm) begin
          m_run++;
          if (m_run == (m_alarm ? CTH : ETH)) begin
            m_alarm = !m_alarm;
            m_run   = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    bit has;
    has = (m_q.size() > 0);
    check("ready_in", 32'(READY_IN), 32'(m_q.size() < DEPTH));
    check("valid_out", 32'(VALID_OUT), 32'(has));
    check("d_out", D_OUT, has ? m_q[0][32:1] : 32'h0);
    check("err_out", 32'(ERR_OUT), has ? 32'(m_q[0][0]) : 32'h0);
    check("good_cnt", 32'(GOOD_CNT), 32'(m_good));
    check("bad_cnt", 32'(BAD_CNT), 32'(m_bad));
    check("alarm", 32'(ALARM), 32'(m_alarm));
  endtask

  task automatic step(input bit rst, input bit vin, input logic [35:0] din, input bit rout);
    RST       = rst;
    VALID_IN  = vin;
    D_IN      = din;
    READY_OUT = rout;
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    compare_all();
  endtask

  initial begin
    step(1, 0, 36'h0, 1);
    step(1, 0, 36'h0, 1);
    check("lit_rst_ready", 32'(READY_IN), 32'd1);
    check("lit_rst_valid", 32'(VALID_OUT), 32'd0);
    check("lit_rst_dout", D_OUT, 32'h0);
    check("lit_model_g1", 32'(mk_good(32'h1)), 32'h13);

    // good / good / bad
    step(0, 1, 36'h000000013, 1);
    check("lit_w1_d", D_OUT, 32'h00000001);
    check("lit_w1_e", 32'(ERR_OUT), 32'd0);
    step(0, 1, 36'h800000006, 1);
    check("lit_w2_d", D_OUT, 32'h80000000);
    check("lit_w2_e", 32'(ERR_OUT), 32'd0);
    step(0, 1, 36'h000000010, 1);
    check("lit_w3_d", D_OUT, 32'h00000001);
    check("lit_w3_e", 32'(ERR_OUT), 32'd1);
    step(0, 0, 36'h0, 1);
    check("lit_good2", 32'(GOOD_CNT), 32'd2);
    check("lit_bad1", 32'(BAD_CNT), 32'd1);

    // backpressure: 6 offered, 4 accepted
    for (int i = 0; i < 6; i++) begin
      step(0, 1, mk_good(32'h100 + 32'(i)), 0);
      if (i == 3) check("lit_full", 32'(READY_IN), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      check("lit_drain", D_OUT, 32'h100 + 32'(i));
      step(0, 0, 36'h0, 1);
    end
    check("lit_drained", 32'(VALID_OUT), 32'd0);
    step(0, 1, mk_good(32'h1FF), 1);
    check("lit_resume", D_OUT, 32'h1FF);
    step(0, 0, 36'h0, 1);

    // simultaneous push and pop at occupancy 2
    step(0, 1, mk_good(32'h200), 0);
    step(0, 1, mk_good(32'h201), 0);
    step(0, 1, mk_good(32'h202), 1);
    check("lit_pp_head", D_OUT, 32'h201);
    step(0, 0, 36'h0, 1);
    check("lit_pp_next", D_OUT, 32'h202);
    step(0, 0, 36'h0, 1);
    check("lit_pp_empty", 32'(VALID_OUT), 32'd0);

    // alarm raise, interleave stays in alarm
    for (int i = 0; i < 3; i++) begin
      step(0, 1, mk_bad(32'h300 + 32'(i)), 1);
      if (i == 1) check("lit_pre_alarm", 32'(ALARM), 32'd0);
    end
    check("lit_alarm_on", 32'(ALARM), 32'd1);
    step(0, 1, mk_good(32'h310), 1);
    step(0, 1, mk_bad(32'h311), 1);
    step(0, 0, 36'h0, 1);
    check("lit_alarm_hold", 32'(ALARM), 32'd1);

    // mid-operation reset with 3 queued words
    for (int i = 0; i < 3; i++) step(0, 1, mk_good(32'h400 + 32'(i)), 0);
    check("lit_bad5", 32'(BAD_CNT), 32'd5);
    check("lit_q3_alarm", 32'(ALARM), 32'd1);
    step(1, 1, mk_good(32'h4FF), 1);
    check("lit_mr_valid", 32'(VALID_OUT), 32'd0);
    check("lit_mr_bad", 32'(BAD_CNT), 32'd0);
    check("lit_mr_alarm", 32'(ALARM), 32'd0);
    step(0, 0, 36'h0, 1);
    check("lit_mr_stale", 32'(VALID_OUT), 32'd0);

    // alarm clear after 8 consecutive good words
    for (int i = 0; i < 3; i++) step(0, 1, mk_bad(32'h500 + 32'(i)), 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, mk_good(32'h600 + 32'(i)), 1);
      if (i == 6) check("lit_alarm_7g", 32'(ALARM), 32'd1);
    end
    check("lit_alarm_off", 32'(ALARM), 32'd0);
    step(0, 0, 36'h0, 1);

    // saturation
    force dut.bad_cnt_reg = 16'hFFFE;
    m_bad = 16'hFFFE;
    step(0, 0, 36'h0, 1);
    release dut.bad_cnt_reg;
    for (int i = 0; i < 3; i++) step(0, 1, mk_bad(32'h700 + 32'(i)), 1);
    step(0, 0, 36'h0, 1);
    check("lit_sat", 32'(BAD_CNT), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
